// File: rtl/lz_decoder.sv
// lz_decoder: rebuilds a one-hot data word from a leading-zero count behind a 2-entry skid buffer
module lz_decoder #(
  parameter int DATA_WIDTH    = 10,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH + 1),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CNT_WIDTH-1:0]     cnt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] dec_data, tail_data;
  logic                  dec_err, tail_err;
  logic                  in_xfer, out_xfer;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign dec_err   = cnt > CNT_WIDTH'(DATA_WIDTH);
  // Bit i is set when the count places the single one at position i; counts >= DATA_WIDTH give zero
  always_comb begin
    dec_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) dec_data[i] = cnt == CNT_WIDTH'(DATA_WIDTH - 1 - i);
  end
  // Buffer occupancy register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else state <= state_nxt;
  end
  // Occupancy transitions; in and out together in ONE keeps the occupancy unchanged
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   state_nxt = in_xfer ? ONE : EMPTY;
      ONE:     state_nxt = (in_xfer && !out_xfer) ? FULL : ((!in_xfer && out_xfer) ? EMPTY : ONE);
      FULL:    state_nxt = out_xfer ? ONE : FULL;
      default: state_nxt = EMPTY;
    endcase
  end
  // Head entry drives the outputs directly; it is cleared when the buffer drains so data reads 0 when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      err       <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (in_xfer && (state == EMPTY || out_xfer)) begin
        data <= dec_data;
        err  <= dec_err;
      end else if (out_xfer) begin
        data <= state == FULL ? tail_data : '0;
        err  <= state == FULL ? tail_err : 1'b0;
      end
      if (in_xfer && state == ONE && !out_xfer) begin
        tail_data <= dec_data;
        tail_err  <= dec_err;
      end
      if (in_xfer && dec_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_lz_decoder.sv
// tb_lz_decoder: directed and random checks of lz_decoder against a queue-based scoreboard
module tb_lz_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] cnt = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] data;
  logic       err;
  logic [7:0] err_cnt;
  logic [10:0] sb[$];
  int compared = 0;
  int mismatched = 0;
  int err_model = 0;
  lz_decoder #(.DATA_WIDTH(10), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cnt(cnt),
    .out_valid(out_valid), .out_ready(out_ready), .data(data), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  // Compare one observed value with its expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [10:0] model(input logic [3:0] c);
    logic [9:0] top;
    top = 10'b1000000000;
    return {c > 4'd10, c < 4'd10 ? (top >> c) : 10'd0};
  endfunction
  function automatic int lz(input logic [9:0] d);
    for (int i = 9; i >= 0; i--) if (d[i]) return 9 - i;
    return 10;
  endfunction
  // One clock: evaluate handshakes at the negedge, then advance past the next rising edge
  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 32'(out_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_data", 32'(data), 32'(e[9:0]));
        chk("sb_err", 32'(err), 32'(e[10]));
      end
    end
    if (!rst && in_valid && in_ready) begin
      sb.push_back(model(cnt));
      if (cnt > 4'd10 && err_model < 255) err_model++;
    end
    if (rst) begin
      sb.delete();
      err_model = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [9:0] dec_exp[4];
    logic [3:0] dec_cnt[4];
    dec_cnt = '{4'd0, 4'd4, 4'd9, 4'd10};
    dec_exp = '{10'b1000000000, 10'b0000100000, 10'b0000000001, 10'b0000000000};
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      cnt = dec_cnt[k];
      tick();
      in_valid = 1'b0;
      chk("dec_latency_valid", 32'(out_valid), 32'd1);
      chk("dec_data", 32'(data), 32'(dec_exp[k]));
      chk("dec_err", 32'(err), 32'd0);
      tick();
    end
    in_valid = 1'b1;
    cnt = 4'd11;
    tick();
    chk("err11_flag", 32'(err), 32'd1);
    chk("err11_data", 32'(data), 32'd0);
    cnt = 4'd15;
    tick();
    chk("err15_flag", 32'(err), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("err_cnt_two", 32'(err_cnt), 32'd2);
    in_valid = 1'b1;
    cnt = 4'd12;
    for (int k = 0; k < 300; k++) tick();
    in_valid = 1'b0;
    tick();
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("err_cnt_sat_model", 32'(err_cnt), 32'(err_model));
    out_ready = 1'b0;
    in_valid = 1'b1;
    cnt = 4'd1;
    tick();
    chk("bp_first_ready", 32'(in_ready), 32'd1);
    cnt = 4'd2;
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    cnt = 4'd3;
    tick();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    chk("bp_hold_data", 32'(data), 32'(10'b0100000000));
    tick();
    chk("bp_hold_data2", 32'(data), 32'(10'b0100000000));
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_second_head", 32'(data), 32'(10'b0010000000));
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_third_head", 32'(data), 32'(10'b0001000000));
    tick();
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      cnt = 4'(c);
      tick();
      chk("tp_valid", 32'(out_valid), 32'd1);
      chk("tp_ready", 32'(in_ready), 32'd1);
      chk("tp_roundtrip", 32'(lz(data)), 32'(c));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    cnt = 4'd5;
    tick();
    cnt = 4'd6;
    tick();
    chk("rm_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    cnt = 4'd7;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    chk("rm_err_cnt", 32'(err_cnt), 32'd0);
    chk("rm_data", 32'(data), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rm_no_stale", 32'(out_valid), 32'd0);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    cnt = 4'd13;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_input_ignored_valid", 32'(out_valid), 32'd0);
    chk("rst_input_ignored_err", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 10000; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cnt = 4'($urandom_range(0, 15));
      tick();
      chk("rnd_err_cnt", 32'(err_cnt), 32'(err_model));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("rnd_drained", 32'(sb.size()), 32'd0);
    chk("rnd_idle", 32'(out_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
